cu_sequencer: RTL and testbench

//  Control unit that drives the register bank (RB) as its initiator: fetches 16-bit

---
 rtl/cu_sequencer_if.sv | 33 +++
 rtl/cu_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_cu_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_sequencer_if.sv
`default_nettype none
// ============================================================================
// cu_sequencer_if : instruction-fetch bus and register-bank control bundle
// Rev 1.0
// ============================================================================
interface cu_sequencer_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
);
  logic [PC_W-1:0]   instr_addr;
  logic              instr_req;
  logic              instr_valid;
  logic [15:0]       instr_data;
  logic [2:0]        InMuxAdd;
  logic [3:0]        RegAdd;
  logic              WE;
  logic [DATA_W-1:0] CUconst;
  logic [3:0]        OutMuxAdd;
  logic [3:0]        ALUop;

  modport master (
    output instr_addr, instr_req,
    input  instr_valid, instr_data,
    output InMuxAdd, RegAdd, WE, CUconst, OutMuxAdd, ALUop
  );

  modport slave (
    input  instr_addr, instr_req,
    output instr_valid, instr_data,
    input  InMuxAdd, RegAdd, WE, CUconst, OutMuxAdd, ALUop
  );
endinterface
`default_nettype wire

// File: rtl/cu_sequencer.sv
`default_nettype none
// ============================================================================
// cu_sequencer : fetch/decode/execute control unit driving register bank + ALU
// Rev 1.0
// ============================================================================
module cu_sequencer #(
  parameter int PC_W     = 8,
  parameter int DATA_W   = 8,
  parameter int PC_RESET = 0
) (
  input  wire            clk,
  input  wire            reset,
  input  wire            start,
  input  wire            alu_zero,
  output logic           busy,
  output logic           halted,
  output logic           illegal,
  cu_sequencer_if.master bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [3:0] OP_LDA    = 4'h1;
  localparam logic [3:0] OP_LDB    = 4'h2;
  localparam logic [3:0] OP_LDI    = 4'h3;
  localparam logic [3:0] OP_ALU    = 4'h4;
  localparam logic [3:0] OP_OUT    = 4'h5;
  localparam logic [3:0] OP_JMP    = 4'h6;
  localparam logic [3:0] OP_JZ     = 4'h7;
  localparam logic [3:0] OP_ILL_LO = 4'h8;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [2:0] IN_A     = 3'd0;
  localparam logic [2:0] IN_B     = 3'd1;
  localparam logic [2:0] IN_CONST = 3'd2;
  localparam logic [2:0] IN_ALU   = 3'd3;

  localparam logic [PC_W-1:0] PC_RESET_V = PC_W'(PC_RESET);

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [3:0]      out_mux;

  logic [3:0]      op;
  logic [3:0]      rd;
  logic [7:0]      imm;
  logic [3:0]      func;
  logic [PC_W-1:0] jump_target;

  logic [2:0]        in_mux;
  logic [3:0]        reg_add;
  logic              we;
  logic [DATA_W-1:0] cu_const;
  logic [3:0]        alu_op;
  logic              instr_req;

  assign op          = ir[15:12];
  assign rd          = ir[11:8];
  assign imm         = ir[7:0];
  assign func        = ir[3:0];
  assign jump_target = PC_W'(imm);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A jump/branch in DECODE overrides the increment taken in the preceding FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= PC_RESET_V;
      ir      <= 16'h0000;
      out_mux <= 4'h0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (bus.instr_valid) begin
            ir <= bus.instr_data;
            pc <= pc + PC_W'(1);
          end
        end
        ST_DECODE: begin
          case (op)
            OP_OUT:  out_mux <= imm[3:0];
            OP_JMP:  pc <= jump_target;
            OP_JZ:   if (alu_zero) pc <= jump_target;
            default: ;
          endcase
        end
        ST_HALT: begin
          if (start) pc <= PC_RESET_V;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_FETCH;
      ST_FETCH:  if (bus.instr_valid) state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_ALU:  state_nxt = ST_EXEC;
          OP_HALT: state_nxt = ST_HALT;
          default: state_nxt = ST_FETCH;
        endcase
      end
      ST_EXEC:   state_nxt = ST_FETCH;
      ST_HALT:   if (start) state_nxt = ST_FETCH;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Register-bank controls are purely state+IR so they drop to zero outside DECODE/EXEC.
  always_comb begin
    in_mux    = IN_A;
    reg_add   = 4'h0;
    we        = 1'b0;
    cu_const  = '0;
    alu_op    = 4'h0;
    instr_req = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state)
      ST_FETCH: begin
        instr_req = 1'b1;
        busy      = 1'b1;
      end
      ST_DECODE: begin
        busy = 1'b1;
        case (op)
          OP_LDA: begin
            we      = 1'b1;
            reg_add = rd;
            in_mux  = IN_A;
          end
          OP_LDB: begin
            we      = 1'b1;
            reg_add = rd;
            in_mux  = IN_B;
          end
          OP_LDI: begin
            we       = 1'b1;
            reg_add  = rd;
            in_mux   = IN_CONST;
            cu_const = DATA_W'(imm);
          end
          OP_ALU:  alu_op = func;
          default: illegal = (op >= OP_ILL_LO) && (op != OP_HALT);
        endcase
      end
      ST_EXEC: begin
        busy    = 1'b1;
        we      = 1'b1;
        reg_add = rd;
        in_mux  = IN_ALU;
        alu_op  = func;
      end
      ST_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.instr_addr = pc;
  assign bus.instr_req  = instr_req;
  assign bus.InMuxAdd   = in_mux;
  assign bus.RegAdd     = reg_add;
  assign bus.WE         = we;
  assign bus.CUconst    = cu_const;
  assign bus.OutMuxAdd  = out_mux;
  assign bus.ALUop      = alu_op;

endmodule
`default_nettype wire

// File: tb/tb_cu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cu_sequencer : instruction-level model checked against cu_sequencer each cycle
// Rev 1.0
// ============================================================================
module tb_cu_sequencer;
  localparam int PC_W   = 8;
  localparam int DATA_W = 8;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic alu_zero = 1'b0;
  logic busy, halted, illegal;

  cu_sequencer_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

  cu_sequencer #(.PC_W(PC_W), .DATA_W(DATA_W), .PC_RESET(0)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_zero(alu_zero),
    .busy(busy), .halted(halted), .illegal(illegal), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [7:0] addr;
    logic [2:0] inmux;
    logic [3:0] regadd;
    logic       we;
    logic [7:0] cuconst;
    logic [3:0] outmux;
    logic [3:0] aluop;
    logic       busy;
    logic       halted;
    logic       illegal;
    int         tag;   // 0 idle/fetch/halt, 1 decode, 2 exec
  } exp_t;

  exp_t        q[$];
  logic [15:0] mem[256];
  logic [7:0]  m_pc;
  logic [3:0]  m_outmux;
  int          mode;
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          wait_cnt, nfetch, dly_override, last_tag;
  bit          last_from_q, start_req, az, noise;
  int          dly_tab[5] = '{0, 1, 2, 0, 3};

  task automatic chk(string name, logic [15:0] act, logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cycle, act, expv);
    end
  endtask

  function automatic exp_t base_vec();
    exp_t e;
    e = '{default: '0};
    e.addr   = m_pc;
    e.outmux = m_outmux;
    if (mode == M_RUN) begin
      e.req  = 1'b1;
      e.busy = 1'b1;
    end else if (mode == M_HALT) begin
      e.halted = 1'b1;
    end
    return e;
  endfunction

  task automatic compare(exp_t e);
    chk("instr_req", bus.instr_req, e.req);
    chk("instr_addr", bus.instr_addr, e.addr);
    chk("InMuxAdd", bus.InMuxAdd, e.inmux);
    chk("RegAdd", bus.RegAdd, e.regadd);
    chk("WE", bus.WE, e.we);
    chk("CUconst", bus.CUconst, e.cuconst);
    chk("OutMuxAdd", bus.OutMuxAdd, e.outmux);
    chk("ALUop", bus.ALUop, e.aluop);
    chk("busy", busy, e.busy);
    chk("halted", halted, e.halted);
    chk("illegal", illegal, e.illegal);
  endtask

  // Queue the cycle-by-cycle outputs one fetched instruction produces, then apply its effects.
  task automatic model_fetch(logic [15:0] w);
    exp_t d, x;
    logic [3:0] op;
    op   = w[15:12];
    m_pc = m_pc + 8'd1;
    d = '{default: '0};
    d.addr = m_pc; d.outmux = m_outmux; d.busy = 1'b1; d.tag = 1;
    case (op)
      4'h1: begin d.we = 1'b1; d.regadd = w[11:8]; d.inmux = 3'd0; end
      4'h2: begin d.we = 1'b1; d.regadd = w[11:8]; d.inmux = 3'd1; end
      4'h3: begin d.we = 1'b1; d.regadd = w[11:8]; d.inmux = 3'd2; d.cuconst = w[7:0]; end
      4'h4: d.aluop = w[3:0];
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: d.illegal = 1'b1;
      default: ;
    endcase
    q.push_back(d);
    if (op == 4'h4) begin
      x = d;
      x.aluop = w[3:0]; x.we = 1'b1; x.inmux = 3'd3; x.regadd = w[11:8]; x.tag = 2;
      q.push_back(x);
    end
    if (op == 4'h5) m_outmux = w[3:0];
    if (op == 4'h6 || (op == 4'h7 && az)) m_pc = w[7:0];
    if (op == 4'hF) mode = M_HALT;
  endtask

  task automatic model_reset();
    q.delete();
    mode = M_IDLE; m_pc = 8'h00; m_outmux = 4'h0; wait_cnt = 0;
  endtask

  function automatic int cur_delay();
    if (dly_override >= 0) return dly_override;
    return dly_tab[nfetch % 5];
  endfunction

  task automatic step();
    exp_t e;
    @(negedge clk);
    cycle++;
    if (q.size() > 0) begin
      e = q.pop_front();
      last_from_q = 1'b1;
    end else begin
      e = base_vec();
      last_from_q = 1'b0;
    end
    last_tag = e.tag;
    compare(e);
    start = 1'b0; bus.instr_valid = 1'b0; bus.instr_data = 16'h0000; alu_zero = az;
    if (!last_from_q && mode == M_RUN) begin
      if (wait_cnt >= cur_delay()) begin
        bus.instr_valid = 1'b1;
        bus.instr_data  = mem[m_pc];
        wait_cnt = 0; nfetch++; dly_override = -1;
        model_fetch(mem[m_pc]);
      end else begin
        wait_cnt++;
        if (noise) bus.instr_data = 16'hF0F0;
      end
    end else begin
      if (noise) begin bus.instr_valid = 1'b1; bus.instr_data = 16'hF000; end
      if (!last_from_q && mode != M_RUN && start_req) begin
        start = 1'b1;
        if (mode == M_HALT) m_pc = 8'h00;
        mode = M_RUN;
        start_req = 1'b0;
      end
    end
  endtask

  task automatic step_until_decode(string what);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (last_from_q && last_tag == 1) done = 1'b1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL timeout_%s cycle=%0d actual=no_decode required=decode", what, cycle);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h332A;  // LDI r3,0x2A
    mem[8'h01] = 16'h4502;  // ALU r5,func 2
    mem[8'h02] = 16'h1100;  // LDA r1
    mem[8'h03] = 16'h2200;  // LDB r2
    mem[8'h04] = 16'h5007;  // OUT 7
    mem[8'h05] = 16'h9000;  // undefined opcode
    mem[8'h06] = 16'h7010;  // JZ 0x10 (not taken)
    mem[8'h07] = 16'h6010;  // JMP 0x10
    mem[8'h10] = 16'h7020;  // JZ 0x20 (taken)
    mem[8'h20] = 16'h60FF;  // JMP 0xFF
    mem[8'hFF] = 16'h0000;  // NOP, pc wraps to 0
    bus.instr_valid = 1'b0; bus.instr_data = 16'h0000;
    noise = 1'b1; az = 1'b0; start_req = 1'b0;
    dly_override = -1; nfetch = 0;
    model_reset();

    step(); step();
    reset = 1'b1;
    step();
    start_req = 1'b1;

    step_until_decode("ldi");
    chk("ldi_we", bus.WE, 1); chk("ldi_regadd", bus.RegAdd, 3);
    chk("ldi_inmux", bus.InMuxAdd, 2); chk("ldi_const", bus.CUconst, 16'h2A);
    step_until_decode("alu");
    chk("alu_dec_op", bus.ALUop, 2); chk("alu_dec_we", bus.WE, 0);
    step();
    chk("alu_exec_we", bus.WE, 1); chk("alu_exec_inmux", bus.InMuxAdd, 3);
    chk("alu_exec_regadd", bus.RegAdd, 5);
    step();
    chk("alu_after_we", bus.WE, 0);

    step_until_decode("lda");
    chk("lda_regadd", bus.RegAdd, 1);
    dly_override = 4;
    repeat (4) step();
    chk("wait_req", bus.instr_req, 1); chk("wait_addr", bus.instr_addr, 3);
    chk("wait_we", bus.WE, 0);
    step_until_decode("ldb");
    chk("ldb_inmux", bus.InMuxAdd, 1);

    step_until_decode("out");
    step();
    chk("out_mux", bus.OutMuxAdd, 7);
    step_until_decode("illegal");
    chk("illegal_pulse", illegal, 1);
    step();
    chk("illegal_clear", illegal, 0);

    step_until_decode("jz_not_taken");
    step();
    chk("jz_nt_addr", bus.instr_addr, 8'h07);
    az = 1'b1;
    step_until_decode("jmp");
    step_until_decode("jz_taken");
    step();
    chk("jz_t_addr", bus.instr_addr, 8'h20);
    step_until_decode("jmp_ff");
    step();
    chk("jmp_ff_addr", bus.instr_addr, 8'hFF);
    step_until_decode("nop_ff");
    step();
    chk("wrap_addr", bus.instr_addr, 8'h00); chk("wrap_req", bus.instr_req, 1);

    // Second trip through LDI/ALU; reset lands in the middle of the EXEC cycle.
    step_until_decode("ldi2");
    step_until_decode("alu2");
    @(posedge clk); #2;
    chk("exec_we_pre_reset", bus.WE, 1);
    reset = 1'b0;
    #1;
    chk("rst_we", bus.WE, 0); chk("rst_busy", busy, 0);
    chk("rst_addr", bus.instr_addr, 0); chk("rst_inmux", bus.InMuxAdd, 0);
    model_reset();
    step();
    reset = 1'b1;

    mem[8'h02] = 16'hF000;  // HALT
    start_req = 1'b1;
    step_until_decode("ldi3");
    step_until_decode("alu3");
    step_until_decode("halt");
    step();
    chk("halt_halted", halted, 1); chk("halt_req", bus.instr_req, 0);
    chk("halt_busy", busy, 0);
    repeat (3) step();

    mem[8'h00] = 16'h6000;  // JMP 0: tight loop on its own address
    start_req = 1'b1;
    step();
    step();
    chk("restart_addr", bus.instr_addr, 0); chk("restart_req", bus.instr_req, 1);
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
